mult_div_unit: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It sits beside the ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It holds the pipeline through a combinational `stall` while an operation is in flight. It is the successor to the fixed 32-bit multiply-only path: width and radix are generic, it adds signed/unsigned division, and HI/LO state is owned locally.

---
 rtl/mult_div_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit that owns the architectural HI/LO registers.
// Executes MULT, MULTU, DIV, DIVU with a shift-add / restoring shift-subtract datapath,
// plus single-cycle MTHI/MTLO writes.
//
// Ports:
//   clk            - sole clock, rising edge
//   reset          - asynchronous, active-high; clears all state
//   start          - qualifies ALU_operation for one cycle
//   ALU_operation  - 6-bit function code
//   input_1        - multiplicand / dividend / MTHI-MTLO source
//   input_2        - multiplier / divisor
//   hi_output      - HI register (remainder for division)
//   lo_output      - LO register (quotient for division)
//   stall          - combinational busy indication (includes the accepting cycle)
//   done           - registered one-cycle pulse after a mult/div writes HI/LO
module mult_div_unit #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       ALU_operation,
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  output logic [WIDTH-1:0] hi_output,
  output logic [WIDTH-1:0] lo_output,
  output logic             stall,
  output logic             done
);

  localparam int unsigned Iters = WIDTH / STEPS_PER_CYCLE;
  localparam int unsigned CntW  = $clog2(Iters + 1);

  localparam logic [5:0] OpMult  = 6'b011000;
  localparam logic [5:0] OpMultu = 6'b011001;
  localparam logic [5:0] OpDiv   = 6'b011010;
  localparam logic [5:0] OpDivu  = 6'b011011;
  localparam logic [5:0] OpMthi  = 6'b010001;
  localparam logic [5:0] OpMtlo  = 6'b010011;

  typedef enum logic [1:0] {StIdle, StCalc, StFixup} state_e;

  state_e             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               neg_q_q, neg_q_d;   // product / quotient sign
  logic               neg_r_q, neg_r_d;   // remainder sign
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic is_muldiv;
  logic accept;

  assign is_muldiv = (ALU_operation == OpMult) || (ALU_operation == OpMultu) ||
                     (ALU_operation == OpDiv)  || (ALU_operation == OpDivu);
  assign accept    = start && (state_q == StIdle) && is_muldiv;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StCalc;
      StCalc:  if (cnt_q == CntW'(1)) state_d = StFixup;
      StFixup: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    stall = (state_q != StIdle) || accept;
  end

  // Datapath next-state
  always_comb begin
    logic               sign1;
    logic               sign2;
    logic               signed_op;
    logic [2*WIDTH-1:0] acc_v;
    logic [2*WIDTH-1:0] prod_v;
    logic [WIDTH-1:0]   rem_v;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     sum_v;

    is_div_d  = is_div_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    div0_d    = div0_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    sign1     = 1'b0;
    sign2     = 1'b0;
    signed_op = 1'b0;
    acc_v     = acc_q;
    rem_v     = rem_q;
    rem_sh    = '0;
    sum_v     = '0;
    prod_v    = '0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // Bit 0 of the function code distinguishes unsigned, bit 1 divide.
          signed_op = ~ALU_operation[0];
          sign1     = signed_op & input_1[WIDTH-1];
          sign2     = signed_op & input_2[WIDTH-1];
          mag_a_d   = sign1 ? -input_1 : input_1;
          mag_b_d   = sign2 ? -input_2 : input_2;
          is_div_d  = ALU_operation[1];
          neg_q_d   = sign1 ^ sign2;
          neg_r_d   = sign1;
          div0_d    = (input_2 == '0);
          // Multiply keeps the multiplier in the low half; divide shifts the dividend out of it.
          acc_d     = {{WIDTH{1'b0}}, (ALU_operation[1] ? mag_a_d : mag_b_d)};
          rem_d     = '0;
          cnt_d     = CntW'(Iters);
        end else if (start && (ALU_operation == OpMthi)) begin
          hi_d = input_1;
        end else if (start && (ALU_operation == OpMtlo)) begin
          lo_d = input_1;
        end
      end
      StCalc: begin
        for (int unsigned s = 0; s < STEPS_PER_CYCLE; s++) begin
          if (!is_div_q) begin
            sum_v = {1'b0, acc_v[2*WIDTH-1:WIDTH]} + {1'b0, (acc_v[0] ? mag_a_q : '0)};
            acc_v = {sum_v, acc_v[WIDTH-1:1]};
          end else begin
            rem_sh = {rem_v, acc_v[WIDTH-1]};
            acc_v[WIDTH-1:0] = {acc_v[WIDTH-2:0], 1'b0};
            if (rem_sh >= {1'b0, mag_b_q}) begin
              // True difference is below the divisor, so modulo-2^WIDTH is exact.
              rem_v    = rem_sh[WIDTH-1:0] - mag_b_q;
              acc_v[0] = 1'b1;
            end else begin
              rem_v = rem_sh[WIDTH-1:0];
            end
          end
        end
        acc_d = acc_v;
        rem_d = rem_v;
        cnt_d = cnt_q - CntW'(1);
      end
      StFixup: begin
        done_d = 1'b1;
        if (!is_div_q) begin
          prod_v = neg_q_q ? -acc_q : acc_q;
          hi_d   = prod_v[2*WIDTH-1:WIDTH];
          lo_d   = prod_v[WIDTH-1:0];
        end else begin
          // With a zero divisor the remainder naturally equals |dividend|, so the
          // remainder sign fix restores input_1; only the quotient needs overriding.
          hi_d = neg_r_q ? -rem_q : rem_q;
          if (div0_q) begin
            lo_d = '1;
          end else begin
            lo_d = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi_output = hi_q;
  assign lo_output = lo_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a default 32-bit instance driven from a vector
// table, hand sequences and random ops, plus three 8-bit instances (1, 2, 4 steps/cycle)
// run in lockstep on random ops against an arithmetic reference model.
module tb_mult_div_unit;

  localparam logic [5:0] OpMult  = 6'b011000;
  localparam logic [5:0] OpMultu = 6'b011001;
  localparam logic [5:0] OpDiv   = 6'b011010;
  localparam logic [5:0] OpDivu  = 6'b011011;
  localparam logic [5:0] OpMthi  = 6'b010001;
  localparam logic [5:0] OpMtlo  = 6'b010011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start32 = 1'b0;
  logic [5:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [31:0] hi32, lo32;
  logic        stall32, done32;

  logic        start8 = 1'b0;
  logic [5:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [7:0]  hi8 [3];
  logic [7:0]  lo8 [3];
  logic        stall8 [3];
  logic        done8 [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mult_div_unit u_dut32 (
    .clk          (clk),
    .reset        (reset),
    .start        (start32),
    .ALU_operation(op32),
    .input_1      (a32),
    .input_2      (b32),
    .hi_output    (hi32),
    .lo_output    (lo32),
    .stall        (stall32),
    .done         (done32)
  );

  for (genvar g = 0; g < 3; g++) begin : g_w8
    mult_div_unit #(
      .WIDTH          (8),
      .STEPS_PER_CYCLE(1 << g)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start8),
      .ALU_operation(op8),
      .input_1      (a8),
      .input_2      (b8),
      .hi_output    (hi8[g]),
      .lo_output    (lo8[g]),
      .stall        (stall8[g]),
      .done         (done8[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic at width w, returns {hi, lo}.
  function automatic logic [63:0] ref_md(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input int w);
    logic [63:0] mask, hi, lo, up;
    longint      sa, sb, sp, q, r;
    mask = (64'd1 << w) - 64'd1;
    sa = a[w-1] ? $signed({32'd0, a}) - $signed(64'd1 << w) : $signed({32'd0, a});
    sb = b[w-1] ? $signed({32'd0, b}) - $signed(64'd1 << w) : $signed({32'd0, b});
    hi = '0;
    lo = '0;
    case (op)
      OpMult: begin
        sp = sa * sb;
        hi = (64'(sp) >> w) & mask;
        lo = 64'(sp) & mask;
      end
      OpMultu: begin
        up = {32'd0, a} * {32'd0, b};
        hi = (up >> w) & mask;
        lo = up & mask;
      end
      OpDiv, OpDivu: begin
        if (b == 32'd0) begin
          hi = {32'd0, a};
          lo = mask;
        end else if (op == OpDiv) begin
          q  = sa / sb;
          r  = sa % sb;
          hi = 64'(r) & mask;
          lo = 64'(q) & mask;
        end else begin
          hi = {32'd0, a % b};
          lo = {32'd0, a / b};
        end
      end
      default: ;
    endcase
    return {hi[31:0], lo[31:0]};
  endfunction

  // Issues one 32-bit op and waits for done. stall_cnt counts stall-high cycles from the
  // start cycle; done_at is the cycle index (start cycle = 0) where done is seen, -1 if never.
  task automatic issue32(input bit now, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int stall_cnt, output int done_at);
    if (!now) @(negedge clk);
    start32 = 1'b1;
    op32    = op;
    a32     = a;
    b32     = b;
    #1;
    stall_cnt = stall32 ? 1 : 0;
    done_at   = -1;
    @(negedge clk);
    start32 = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (done32) begin
        done_at = k;
        break;
      end
      if (stall32) stall_cnt++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs[$];
    int          sc, da;
    logic [31:0] hold_hi, hold_lo, ra, rb;
    logic [5:0]  rop;
    logic [63:0] exp;
    logic [5:0]  ops[4];
    int          done_at8[3];
    int          dones;

    ops[0] = OpMult; ops[1] = OpMultu; ops[2] = OpDiv; ops[3] = OpDivu;

    vecs.push_back('{"mult_neg1x2",  OpMult,  32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE});
    vecs.push_back('{"multu_ffx2",   OpMultu, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE});
    vecs.push_back('{"div_m7_2",     OpDiv,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"divu_100_7",   OpDivu,  32'd100,      32'd7, 32'd2,        32'd14});
    vecs.push_back('{"div_ovf",      OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000});
    vecs.push_back('{"divu_by0",     OpDivu,  32'h1234,     32'h0, 32'h1234,     32'hFFFFFFFF});
    vecs.push_back('{"div_by0",      OpDiv,   32'h1234,     32'h0, 32'h1234,     32'hFFFFFFFF});
    vecs.push_back('{"div_negby0",   OpDiv,   32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFF});
    vecs.push_back('{"div_7_m2",     OpDiv,   32'd7, 32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD});
    vecs.push_back('{"mult_min_sq",  OpMult,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0});

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_hi", {32'd0, hi32}, 64'd0);
    chk("rst_lo", {32'd0, lo32}, 64'd0);
    chk("rst_done", {63'd0, done32}, 64'd0);
    chk("rst_stall", {63'd0, stall32}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven directed vectors
    foreach (vecs[i]) begin
      issue32(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, sc, da);
      chk({vecs[i].name, "_hi"}, {32'd0, hi32}, {32'd0, vecs[i].hi});
      chk({vecs[i].name, "_lo"}, {32'd0, lo32}, {32'd0, vecs[i].lo});
      chk({vecs[i].name, "_stall_cycles"}, 64'(sc), 64'd34);
      chk({vecs[i].name, "_done_cycle"}, 64'(da), 64'd34);
      @(negedge clk);
      chk({vecs[i].name, "_done_pulse"}, {63'd0, done32}, 64'd0);
    end

    // MTHI in IDLE: zero stall, visible next cycle
    @(negedge clk);
    start32 = 1'b1; op32 = OpMthi; a32 = 32'hA5A5A5A5;
    #1;
    chk("mthi_stall", {63'd0, stall32}, 64'd0);
    @(negedge clk);
    start32 = 1'b0;
    chk("mthi_hi", {32'd0, hi32}, 64'hA5A5A5A5);
    chk("mthi_stall_after", {63'd0, stall32}, 64'd0);
    chk("mthi_no_done", {63'd0, done32}, 64'd0);

    // MTLO during CALC is ignored; HI/LO hold until FIXUP
    hold_hi = hi32;
    hold_lo = lo32;
    start32 = 1'b1; op32 = OpMultu; a32 = 32'd3; b32 = 32'd5;
    @(negedge clk);
    start32 = 1'b0;
    repeat (4) @(negedge clk);
    start32 = 1'b1; op32 = OpMtlo; a32 = 32'hDEADBEEF;
    @(negedge clk);
    start32 = 1'b0;
    chk("busy_mtlo_lo_hold", {32'd0, lo32}, {32'd0, hold_lo});
    chk("busy_hi_hold", {32'd0, hi32}, {32'd0, hold_hi});
    chk("busy_stall", {63'd0, stall32}, 64'd1);
    da = -1;
    for (int k = 0; k < 60; k++) begin
      if (done32) begin
        da = k;
        break;
      end
      @(negedge clk);
    end
    chk("busy_done_seen", {63'd0, (da >= 0)}, 64'd1);
    chk("busy_result_lo", {32'd0, lo32}, 64'd15);
    chk("busy_result_hi", {32'd0, hi32}, 64'd0);

    // Back-to-back: new start accepted in the done cycle
    issue32(1'b1, OpMultu, 32'd6, 32'd7, sc, da);
    chk("b2b_lo", {32'd0, lo32}, 64'd42);
    chk("b2b_done_cycle", 64'(da), 64'd34);
    chk("b2b_stall_cycles", 64'(sc), 64'd34);

    // Asynchronous reset mid-CALC of a MULTU
    @(negedge clk);
    start32 = 1'b1; op32 = OpMultu; a32 = 32'h12345678; b32 = 32'h9ABCDEF0;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_hi", {32'd0, hi32}, 64'd0);
    chk("midrst_lo", {32'd0, lo32}, 64'd0);
    chk("midrst_stall", {63'd0, stall32}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (done32) dones++;
      @(negedge clk);
    end
    chk("midrst_no_done", 64'(dones), 64'd0);
    chk("midrst_lo_after", {32'd0, lo32}, 64'd0);

    // Random 32-bit ops
    for (int i = 0; i < 16; i++) begin
      rop = ops[$urandom_range(0, 3)];
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
      exp = ref_md(rop, ra, rb, 32);
      issue32(1'b0, rop, ra, rb, sc, da);
      chk($sformatf("rnd32_%0d_op%0h_%0h_%0h_hi", i, rop, ra, rb), {32'd0, hi32},
          {32'd0, exp[63:32]});
      chk($sformatf("rnd32_%0d_lo", i), {32'd0, lo32}, {32'd0, exp[31:0]});
      chk($sformatf("rnd32_%0d_lat", i), 64'(da), 64'd34);
    end

    // 8-bit parameter sweep: 1, 2, 4 steps per cycle in lockstep
    for (int i = 0; i < 40; i++) begin
      rop = ops[$urandom_range(0, 3)];
      ra  = {24'd0, 8'($urandom)};
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : {24'd0, 8'($urandom)};
      if (i == 0) begin
        rop = OpDiv; ra = 32'h80; rb = 32'hFF;
      end
      exp = ref_md(rop, ra, rb, 8);
      @(negedge clk);
      start8 = 1'b1; op8 = rop; a8 = ra[7:0]; b8 = rb[7:0];
      @(negedge clk);
      start8 = 1'b0;
      for (int g = 0; g < 3; g++) done_at8[g] = -1;
      for (int k = 1; k <= 14; k++) begin
        for (int g = 0; g < 3; g++) if (done8[g] && done_at8[g] < 0) done_at8[g] = k;
        @(negedge clk);
      end
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("w8_s%0d_%0d_op%0h_%0h_%0h_hi", 1 << g, i, rop, ra[7:0], rb[7:0]),
            {56'd0, hi8[g]}, {56'd0, exp[39:32]});
        chk($sformatf("w8_s%0d_%0d_lo", 1 << g, i), {56'd0, lo8[g]}, {56'd0, exp[7:0]});
        chk($sformatf("w8_s%0d_%0d_lat", 1 << g, i), 64'(done_at8[g]),
            64'((8 >> g) + 2));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
